// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory-stage initiator and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one access LATENCY+1 cycles after accept; response held until resp_ready, no new request meanwhile.
// Optional DMEM_RESPONDER_STATS_EN adds load/store/fault access counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic clk,
    input  logic rst,
    dmem_responder_if.slave bus
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] fault_count
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          fault;
    logic          do_write;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [31:0]   sh;
    logic [31:0]   ld_data;
    logic [31:0]   wr_word;
    logic [3:0]    be;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

    assign accept   = (state == IDLE) && ready_q && bus.req_valid;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign idx      = addr_q[AW+1:2];
    assign lane     = addr_q[1:0];
    assign do_write = access && wr_q && !fault && !rst;

    always_comb begin
        fault = 1'b0;
        if (size_q == 2'd3)
            fault = 1'b1;
        if (size_q == 2'd1 && lane[0])
            fault = 1'b1;
        if (size_q == 2'd2 && lane != 2'd0)
            fault = 1'b1;
        if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS))
            fault = 1'b1;
    end

    // Load path: shift the addressed lane(s) down to bit 0, then extend.
    always_comb begin
        word    = mem[idx];
        sh      = word >> {lane, 3'b000};
        ld_data = word;
        case (size_q)
            2'd0:    ld_data = uns_q ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    ld_data = uns_q ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_data = word;
        endcase
    end

    // Store path: replicate data across lanes and let byte enables pick the target.
    always_comb begin
        be      = 4'hF;
        wr_word = wdata_q;
        case (size_q)
            2'd0: begin
                be      = 4'b0001 << lane;
                wr_word = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be      = 4'b0011 << {lane[1], 1'b0};
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'hF;
                wr_word = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_nx = RESP;
                else
                    cnt_nx = cnt - 4'd1;
            end
            RESP: begin
                if (bus.resp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready_q <= (state_nx == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
        end else if (access) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (fault || wr_q) ? 32'd0 : ld_data;
            resp_fault_q <= fault;
        end else if (state == RESP && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
        end
    end

`ifdef DMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
            fault_count <= 32'd0;
        end else if (access) begin
            if (fault)
                fault_count <= fault_count + 32'd1;
            else if (wr_q)
                store_count <= store_count + 32'd1;
            else
                load_count <= load_count + 32'd1;
        end
    end
`endif
endmodule
